// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and counter sizing helpers for the PLL reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pll_seq_pkg;

  // Bring-up FSM states. FAIL is absorbing until reset.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } seq_state_t;

  // Width of a counter that runs 0..max_count-1 and stops there, so it never
  // needs to represent max_count itself. Never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level signal.
// Latency: o_q follows i_d after 2 i_clk edges.
// Backpressure: none; a pulse shorter than one clock may be missed.
// Ports:
//   i_clk  destination clock
//   i_rst  asynchronous active-high reset, clears both flops
//   i_d    asynchronous input level
//   o_q    synchronised level
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for a qualified lock, then
// releases NUM_DOMAINS downstream resets one by one, STAGE_GAP cycles apart.
// Latency: locked_in reaches the FSM 2 cycles late; all outputs are flops.
// Backpressure: none; any lock loss after release began restarts the bring-up.
// Ports:
//   clk_in1       PLL reference clock (only clock)
//   reset         asynchronous active-high reset
//   locked_in     raw PLL LOCKED, asynchronous to clk_in1
//   pll_reset     drives the PLL RST input
//   domain_reset  per-domain reset request, bit 0 released first
//   all_ready     high while every domain is released
//   lock_lost     sticky: lock dropped after release began
//   retry_count   lock timeouts in the current bring-up (MAX_RETRIES >= 1)
//   fail          terminal failure, held until reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                               clk_in1,
  input  logic                               reset,
  input  logic                               locked_in,
  output logic                               pll_reset,
  output logic [NUM_DOMAINS-1:0]             domain_reset,
  output logic                               all_ready,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic                               fail
);

  // One shared down-stream counter serves every timed state, so it is sized
  // for the largest interval of them all.
  localparam int CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                  max_of(STABLE_CYCLES, STAGE_GAP));
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int RC_W    = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]       PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]       TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]       STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [RC_W-1:0]        RC_ONE       = RC_W'(1);
  localparam logic [RC_W-1:0]        RC_MAX       = RC_W'(MAX_RETRIES);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL      = '1;

  logic w_locked_s;

  seq_state_t                r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_pll_reset;
  logic [NUM_DOMAINS-1:0]    r_domain_reset;
  logic                      r_all_ready;
  logic                      r_lock_lost;
  logic [RC_W-1:0]           r_retry_count;
  logic                      r_fail;

  sync_2ff u_lock_sync (
    .i_clk (clk_in1),
    .i_rst (reset),
    .i_d   (locked_in),
    .o_q   (w_locked_s)
  );

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_state        <= ST_PLL_RST;
      r_cnt          <= '0;
      r_pll_reset    <= 1'b1;
      r_domain_reset <= DOM_ALL;
      r_all_ready    <= 1'b0;
      r_lock_lost    <= 1'b0;
      r_retry_count  <= '0;
      r_fail         <= 1'b0;
    end else begin
      case (r_state)
        // pll_reset is already high on entry; hold it for PLL_RST_CYCLES edges.
        ST_PLL_RST: begin
          r_domain_reset <= DOM_ALL;
          r_all_ready    <= 1'b0;
          if (r_cnt == PLL_LAST) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          r_domain_reset <= DOM_ALL;
          r_all_ready    <= 1'b0;
          if (w_locked_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            // Timeout: either retry with a fresh PLL reset pulse or give up.
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_retry_count < RC_MAX) begin
              r_retry_count <= r_retry_count + RC_ONE;
              r_state       <= ST_PLL_RST;
            end else begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // Lock must be seen on STABLE_CYCLES consecutive cycles; any drop
        // goes back to WAIT_LOCK, which restarts its timeout from zero.
        ST_STABLE: begin
          r_domain_reset <= DOM_ALL;
          r_all_ready    <= 1'b0;
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            // Domain 0 is released on the same edge RELEASE is entered.
            r_state        <= ST_RELEASE;
            r_cnt          <= '0;
            r_domain_reset <= DOM_ALL << 1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // domain_reset shifts left, so the released bits fill in from bit 0
        // upward; an all-zero vector means the last domain went out last cycle.
        // The lock check comes first so a loss beats a due stage release.
        ST_RELEASE: begin
          if (!w_locked_s) begin
            r_state        <= ST_PLL_RST;
            r_cnt          <= '0;
            r_pll_reset    <= 1'b1;
            r_domain_reset <= DOM_ALL;
            r_all_ready    <= 1'b0;
            r_lock_lost    <= 1'b1;
          end else if (r_domain_reset == '0) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_all_ready   <= 1'b1;
            r_retry_count <= '0;
          end else if (r_cnt == GAP_LAST) begin
            r_cnt          <= '0;
            r_domain_reset <= r_domain_reset << 1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_RUN: begin
          if (!w_locked_s) begin
            // Lock loss in service is not a timeout, so retry_count is untouched.
            r_state        <= ST_PLL_RST;
            r_cnt          <= '0;
            r_pll_reset    <= 1'b1;
            r_domain_reset <= DOM_ALL;
            r_all_ready    <= 1'b0;
            r_lock_lost    <= 1'b1;
          end else begin
            r_domain_reset <= '0;
            r_all_ready    <= 1'b1;
            r_retry_count  <= '0;
          end
        end

        ST_FAIL: begin
          r_pll_reset    <= 1'b1;
          r_domain_reset <= DOM_ALL;
          r_all_ready    <= 1'b0;
          r_fail         <= 1'b1;
        end

        default: begin
          r_state        <= ST_PLL_RST;
          r_cnt          <= '0;
          r_pll_reset    <= 1'b1;
          r_domain_reset <= DOM_ALL;
          r_all_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset    = r_pll_reset;
  assign domain_reset = r_domain_reset;
  assign all_ready    = r_all_ready;
  assign lock_lost    = r_lock_lost;
  assign retry_count  = r_retry_count;
  assign fail         = r_fail;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: table-driven checks of the PLL reset sequencer.
// Latency: expectations are tagged with the cycle count since reset release.
// Backpressure: n/a.
module tb_pll_reset_sequencer;

  localparam int N   = 3;
  localparam int PRC = 4;
  localparam int LTO = 50;
  localparam int STC = 10;
  localparam int GAP = 2;
  localparam int MR  = 2;
  localparam int RCW = $clog2(MR + 1);

  logic           clk_in1 = 1'b0;
  logic           reset = 1'b1;
  logic           locked_in = 1'b0;
  logic           pll_reset;
  logic [N-1:0]   domain_reset;
  logic           all_ready;
  logic           lock_lost;
  logic [RCW-1:0] retry_count;
  logic           fail;

  pll_reset_sequencer #(
    .NUM_DOMAINS    (N),
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LTO),
    .STABLE_CYCLES  (STC),
    .STAGE_GAP      (GAP),
    .MAX_RETRIES    (MR)
  ) dut (
    .clk_in1      (clk_in1),
    .reset        (reset),
    .locked_in    (locked_in),
    .pll_reset    (pll_reset),
    .domain_reset (domain_reset),
    .all_ready    (all_ready),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .fail         (fail)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct {
    int             scn;
    int             cyc;
    logic           pll;
    logic [N-1:0]   dom;
    logic           rdy;
    logic [RCW-1:0] rc;
    logic           lost;
    logic           fl;
  } vec_t;

  typedef struct {
    int   scn;
    int   cyc;
    logic val;
  } lk_t;

  vec_t vtab[$];
  lk_t  ltab[$];
  vec_t sb[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pll_run  = 0;
  int   pll_falls = 0;
  logic pll_prev = 1'b1;

  function automatic void tv(int scn, int cyc, int pll, int dom, int rdy, int rc, int lost, int fl);
    vec_t v;
    v.scn  = scn;
    v.cyc  = cyc;
    v.pll  = 1'(pll);
    v.dom  = N'(dom);
    v.rdy  = 1'(rdy);
    v.rc   = RCW'(rc);
    v.lost = 1'(lost);
    v.fl   = 1'(fl);
    vtab.push_back(v);
  endfunction

  function automatic void lk(int scn, int cyc, int val);
    lk_t l;
    l.scn = scn;
    l.cyc = cyc;
    l.val = 1'(val);
    ltab.push_back(l);
  endfunction

  task automatic check_now(input string tag, input vec_t e);
    n_checks++;
    if (pll_reset !== e.pll || domain_reset !== e.dom || all_ready !== e.rdy ||
        retry_count !== e.rc || lock_lost !== e.lost || fail !== e.fl) begin
      n_fail++;
      $display("FAIL %s: got pll=%b dom=%b rdy=%b rc=%0d lost=%b fail=%b, want pll=%b dom=%b rdy=%b rc=%0d lost=%b fail=%b",
               tag, pll_reset, domain_reset, all_ready, retry_count, lock_lost, fail,
               e.pll, e.dom, e.rdy, e.rc, e.lost, e.fl);
    end
  endtask

  // Called once per cycle, 1ns after the falling edge: pop due expectations,
  // measure pll_reset pulse widths, then drive the scheduled locked_in level.
  task automatic service(input int scn, input int c);
    vec_t e;
    while (sb.size() > 0 && sb[0].cyc == c) begin
      e = sb.pop_front();
      check_now($sformatf("scn%0d_cyc%0d", scn, c), e);
    end
    if (pll_reset === 1'b1) begin
      pll_run++;
    end else if (pll_prev === 1'b1) begin
      pll_falls++;
      n_checks++;
      if (pll_run != PRC) begin
        n_fail++;
        $display("FAIL pll_pulse_width scn%0d cyc%0d: got %0d cycles, want %0d", scn, c, pll_run, PRC);
      end
      pll_run = 0;
    end
    pll_prev = pll_reset;
    foreach (ltab[i]) if (ltab[i].scn == scn && ltab[i].cyc == c) locked_in = ltab[i].val;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    locked_in = 1'b0;
    repeat (2) @(posedge clk_in1);
    @(negedge clk_in1);
    reset = 1'b0;
    #1;
    pll_run   = 0;
    pll_falls = 0;
    pll_prev  = 1'b1;
  endtask

  task automatic run_scenario(input int scn, input int len);
    do_reset();
    foreach (vtab[i]) if (vtab[i].scn == scn) sb.push_back(vtab[i]);
    for (int c = 0; c <= len; c++) begin
      service(scn, c);
      if (c < len) begin
        @(negedge clk_in1);
        #1;
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain scn%0d: got %0d pending, want 0", scn, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;

    // Scenario 0: nominal bring-up, lock loss in RUN, relock, re-release.
    // pll_reset falls at cycle 4; lock driven at 24 is seen by the FSM at 27.
    lk(0, 24, 1); lk(0, 60, 0); lk(0, 70, 1);
    tv(0,  0, 1, 3'b111, 0, 0, 0, 0);
    tv(0,  3, 1, 3'b111, 0, 0, 0, 0);
    tv(0,  4, 0, 3'b111, 0, 0, 0, 0);
    tv(0, 36, 0, 3'b111, 0, 0, 0, 0);
    tv(0, 37, 0, 3'b110, 0, 0, 0, 0);
    tv(0, 38, 0, 3'b110, 0, 0, 0, 0);
    tv(0, 39, 0, 3'b100, 0, 0, 0, 0);
    tv(0, 40, 0, 3'b100, 0, 0, 0, 0);
    tv(0, 41, 0, 3'b000, 0, 0, 0, 0);
    tv(0, 42, 0, 3'b000, 1, 0, 0, 0);
    tv(0, 62, 0, 3'b000, 1, 0, 0, 0);
    tv(0, 63, 1, 3'b111, 0, 0, 1, 0);
    tv(0, 66, 1, 3'b111, 0, 0, 1, 0);
    tv(0, 67, 0, 3'b111, 0, 0, 1, 0);
    tv(0, 82, 0, 3'b111, 0, 0, 1, 0);
    tv(0, 83, 0, 3'b110, 0, 0, 1, 0);
    tv(0, 85, 0, 3'b100, 0, 0, 1, 0);

    // Scenario 1: no lock ever; three 50-cycle timeouts, then FAIL.
    tv(1,   0, 1, 3'b111, 0, 0, 0, 0);
    tv(1,   4, 0, 3'b111, 0, 0, 0, 0);
    tv(1,  53, 0, 3'b111, 0, 0, 0, 0);
    tv(1,  54, 1, 3'b111, 0, 1, 0, 0);
    tv(1,  58, 0, 3'b111, 0, 1, 0, 0);
    tv(1, 107, 0, 3'b111, 0, 1, 0, 0);
    tv(1, 108, 1, 3'b111, 0, 2, 0, 0);
    tv(1, 112, 0, 3'b111, 0, 2, 0, 0);
    tv(1, 161, 0, 3'b111, 0, 2, 0, 0);
    tv(1, 162, 1, 3'b111, 0, 2, 0, 1);
    tv(1, 200, 1, 3'b111, 0, 2, 0, 1);

    // Scenario 2: one-cycle drop seen on the 6th stable cycle (edge 33),
    // relock seen at 34, so release waits for a full fresh count: cycle 44.
    lk(2, 24, 1); lk(2, 30, 0); lk(2, 31, 1);
    tv(2, 37, 0, 3'b111, 0, 0, 0, 0);
    tv(2, 43, 0, 3'b111, 0, 0, 0, 0);
    tv(2, 44, 0, 3'b110, 0, 0, 0, 0);
    tv(2, 46, 0, 3'b100, 0, 0, 0, 0);
    tv(2, 48, 0, 3'b000, 0, 0, 0, 0);
    tv(2, 49, 0, 3'b000, 1, 0, 0, 0);

    // Scenario 3: lock loss seen on edge 39, the edge domain 1 is due.
    lk(3, 24, 1); lk(3, 36, 0);
    tv(3, 38, 0, 3'b110, 0, 0, 0, 0);
    tv(3, 39, 1, 3'b111, 0, 0, 1, 0);
    tv(3, 41, 1, 3'b111, 0, 0, 1, 0);
    tv(3, 43, 0, 3'b111, 0, 0, 1, 0);

    run_scenario(0, 85);

    // Mid-release (domain_reset=100, lock_lost=1): reset must act before the
    // next rising edge, which is 4ns away at this point.
    #1;
    reset = 1'b1;
    #1;
    e = '{scn: 0, cyc: 0, pll: 1'b1, dom: 3'b111, rdy: 1'b0, rc: '0, lost: 1'b0, fl: 1'b0};
    check_now("async_reset_mid_release", e);
    repeat (2) @(posedge clk_in1);
    @(negedge clk_in1);
    reset = 1'b0;
    #1;
    check_now("flags_after_reset_release", e);

    run_scenario(1, 200);
    n_checks++;
    if (pll_falls != 3) begin
      n_fail++;
      $display("FAIL pll_pulse_count: got %0d pulses, want 3", pll_falls);
    end

    run_scenario(2, 50);
    run_scenario(3, 45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
